// File: rtl/demux1to3_16b_if.sv
// Bundles the input handshake, the three destination channels and the discard
// counter of the 1-to-3 router into one connection.
interface demux1to3_16b_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in0;
    logic             in1;
    logic [WIDTH-1:0] b;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] c;
    logic             c_valid;
    logic             c_ready;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_ready;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output in_valid, in_data, in0, in1, b_ready, c_ready, d_ready,
        input  in_ready, b, b_valid, c, c_valid, d, d_valid, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in0, in1, b_ready, c_ready, d_ready,
        output in_ready, b, b_valid, c, c_valid, d, d_valid, drop_cnt
    );
endinterface

// File: rtl/demux1to3_16b.sv
// 16-bit 1-to-3 router: steers each accepted word into one of three one-entry
// holding slots (b, c, d) by its {in1,in0} code; code 00 discards and counts.
module demux1to3_16b #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clkpos,
    input  logic               rstn,
    input  logic               vdd,
    input  logic               vss,
    demux1to3_16b_if.slave     bus
);
    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_FULL   = 1'b1;
    localparam logic [1:0] SEL_DROP = 2'b00;

    // Slot index 0/1/2 corresponds to channel b/c/d (select codes 01/10/11).
    logic [1:0]       sel;
    logic [2:0]       sel_hit;
    logic [2:0]       ch_ready;
    logic [2:0]       load;
    logic [2:0]       drain;
    logic             in_ready;
    logic             accept;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [WIDTH-1:0] data_q [3];
    logic [WIDTH-1:0] data_d [3];
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_d;
    logic             unused_supply;

    assign unused_supply = vdd ^ vss;

    always_comb begin
        sel      = {bus.in1, bus.in0};
        ch_ready = {bus.d_ready, bus.c_ready, bus.b_ready};
        for (int i = 0; i < 3; i++) begin
            sel_hit[i] = (sel == 2'(i + 1));
        end
        // Only the addressed slot can stall the input; a full slot that is
        // draining this cycle can take the new word with no bubble.
        in_ready = (sel == SEL_DROP) | (|(sel_hit & (~state_q | ch_ready)));
        accept   = bus.in_valid & in_ready;
        load     = sel_hit & {3{accept}};
        drain    = state_q & ch_ready;
        for (int i = 0; i < 3; i++) begin
            state_d[i] = load[i] ? S_FULL : (drain[i] ? S_EMPTY : state_q[i]);
            data_d[i]  = load[i] ? bus.in_data : data_q[i];
        end
        drop_d = drop_q;
        if (accept && (sel == SEL_DROP) && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkpos or negedge rstn) begin
        if (!rstn) begin
            state_q <= '0;
            // NOTE: the data holding registers are reset too, because the
            // channel outputs must read zero while the design is in reset.
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
            end
            drop_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q <= state_d;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= data_d[i];
            end
            drop_q <= drop_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.b        = data_q[0];
    assign bus.b_valid  = state_q[0];
    assign bus.c        = data_q[1];
    assign bus.c_valid  = state_q[1];
    assign bus.d        = data_q[2];
    assign bus.d_valid  = state_q[2];
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_demux1to3_16b.sv
// Scoreboard bench for demux1to3_16b: accepted words are queued per channel and
// a negedge monitor pops and compares on every channel handshake.
module tb_demux1to3_16b;
    logic clkpos;
    logic rstn;
    logic vdd;
    logic vss;

    demux1to3_16b_if #(.WIDTH(16), .CNT_W(8)) bus ();

    demux1to3_16b #(.WIDTH(16), .CNT_W(8)) dut (
        .clkpos (clkpos),
        .rstn   (rstn),
        .vdd    (vdd),
        .vss    (vss),
        .bus    (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] q_exp [3][$];
    logic [7:0]  exp_drop = 8'd0;
    string       ch_name [3] = '{"b", "c", "d"};

    initial clkpos = 1'b0;
    always #5 clkpos = ~clkpos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clkpos);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] data, input logic [1:0] sel);
        if (sel == 2'b00) begin
            if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
        end else begin
            q_exp[sel - 2'd1].push_back(data);
        end
    endtask

    // Called at the drive point (posedge+1); returns at the next drive point
    // after the word has been taken, with in_valid dropped again.
    task automatic send(input logic [15:0] data, input logic [1:0] sel);
        int k;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        {bus.in1, bus.in0} = sel;
        k = 0;
        @(negedge clkpos);
        while (!bus.in_ready && k < 20) begin
            @(negedge clkpos);
            k++;
        end
        check("send_accept", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) push_exp(data, sel);
        to_drive();
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every channel handshake must match the head of its queue.
    logic [2:0]  mv;
    logic [2:0]  mr;
    logic [15:0] md [3];
    logic [15:0] exp_w;
    always @(negedge clkpos) begin
        if (rstn) begin
            mv = {bus.d_valid, bus.c_valid, bus.b_valid};
            mr = {bus.d_ready, bus.c_ready, bus.b_ready};
            md[0] = bus.b;
            md[1] = bus.c;
            md[2] = bus.d;
            for (int i = 0; i < 3; i++) begin
                if (mv[i] && mr[i]) begin
                    if (q_exp[i].size() > 0) begin
                        exp_w = q_exp[i].pop_front();
                        check($sformatf("ch_%s_data", ch_name[i]), 32'(md[i]), 32'(exp_w));
                    end else begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL ch_%s_spurious: got word %0h, expected no word", ch_name[i], md[i]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        vdd = 1'b1;
        vss = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.in0 = 1'b0;
        bus.in1 = 1'b0;
        bus.b_ready = 1'b0;
        bus.c_ready = 1'b0;
        bus.d_ready = 1'b0;

        // Reset state and idle in_ready for every select code.
        #1;
        check("rst_valids", 32'({bus.b_valid, bus.c_valid, bus.d_valid}), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);
        check("rst_data", 32'(bus.b | bus.c | bus.d), 32'd0);
        for (int s = 0; s < 4; s++) begin
            {bus.in1, bus.in0} = 2'(s);
            #1;
            check($sformatf("rst_in_ready_sel%0d", s), 32'(bus.in_ready), 32'd1);
        end
        @(negedge clkpos);
        rstn = 1'b1;
        to_drive();

        // Single routes with all consumers ready: one-cycle valid pulses.
        bus.b_ready = 1'b1;
        bus.c_ready = 1'b1;
        bus.d_ready = 1'b1;
        send(16'h1234, 2'b01);
        @(negedge clkpos);
        check("route_b_valid", 32'(bus.b_valid), 32'd1);
        check("route_b_data", 32'(bus.b), 32'h1234);
        @(negedge clkpos);
        check("route_b_pulse", 32'(bus.b_valid), 32'd0);
        to_drive();
        send(16'hABCD, 2'b10);
        @(negedge clkpos);
        check("route_c_data", 32'(bus.c), 32'hABCD);
        check("route_c_only", 32'({bus.b_valid, bus.c_valid, bus.d_valid}), 32'b010);
        to_drive();
        send(16'hFFFF, 2'b11);
        @(negedge clkpos);
        check("route_d_data", 32'(bus.d), 32'hFFFF);
        check("route_d_only", 32'({bus.b_valid, bus.c_valid, bus.d_valid}), 32'b001);
        to_drive();

        // Backpressure on b.
        bus.b_ready = 1'b0;
        send(16'h0001, 2'b01);
        {bus.in1, bus.in0} = 2'b01;
        @(negedge clkpos);
        check("bp_idle_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_b_held", 32'(bus.b), 32'h0001);
        to_drive();
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0002;
        @(negedge clkpos);
        check("bp_stall", 32'(bus.in_ready), 32'd0);
        to_drive();
        bus.in_valid = 1'b0;

        // Non-blocking: b stalled, d still accepts.
        bus.d_ready = 1'b0;
        send(16'h5555, 2'b11);
        @(negedge clkpos);
        check("nb_d_data", 32'(bus.d), 32'h5555);
        check("nb_d_valid", 32'(bus.d_valid), 32'd1);
        check("nb_b_unchanged", 32'({bus.b_valid, bus.b}), 32'h10001);
        to_drive();
        bus.d_ready = 1'b1;

        // Drain-and-refill on b with no bubble.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0002;
        {bus.in1, bus.in0} = 2'b01;
        @(negedge clkpos);
        check("refill_stall", 32'(bus.in_ready), 32'd0);
        to_drive();
        bus.b_ready = 1'b1;
        @(negedge clkpos);
        check("refill_accept", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) push_exp(16'h0002, 2'b01);
        to_drive();
        bus.in_valid = 1'b0;
        @(negedge clkpos);
        check("refill_b", 32'({bus.b_valid, bus.b}), 32'h10002);
        to_drive();

        // Simultaneous accept to c with c and d both draining.
        bus.c_ready = 1'b0;
        send(16'h0C01, 2'b10);
        bus.d_ready = 1'b0;
        send(16'h0D01, 2'b11);
        bus.c_ready = 1'b1;
        bus.d_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h00C0;
        {bus.in1, bus.in0} = 2'b10;
        @(negedge clkpos);
        check("sim_accept", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) push_exp(16'h00C0, 2'b10);
        to_drive();
        bus.in_valid = 1'b0;
        bus.c_ready = 1'b0;
        @(negedge clkpos);
        check("sim_c", 32'({bus.c_valid, bus.c}), 32'h100C0);
        check("sim_d_empty", 32'(bus.d_valid), 32'd0);
        check("sim_drop", 32'(bus.drop_cnt), 32'(exp_drop));
        to_drive();
        bus.c_ready = 1'b1;

        // Discard path: 300 accepted select-00 words saturate at 255.
        bus.in_valid = 1'b1;
        {bus.in1, bus.in0} = 2'b00;
        for (int i = 0; i < 300; i++) begin
            bus.in_data = 16'(i * 7);
            @(posedge clkpos);
            if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
            if (i == 4) begin
                @(negedge clkpos);
                check("drop_5", 32'(bus.drop_cnt), 32'(exp_drop));
            end
        end
        #1;
        bus.in_valid = 1'b0;
        @(negedge clkpos);
        check("drop_sat", 32'(bus.drop_cnt), 32'd255);
        check("drop_no_valid", 32'({bus.b_valid, bus.c_valid, bus.d_valid}), 32'd0);
        repeat (5) @(negedge clkpos);
        check("drop_idle", 32'(bus.drop_cnt), 32'(exp_drop));
        to_drive();

        // Asynchronous reset while b holds a word.
        bus.b_ready = 1'b0;
        send(16'h7777, 2'b01);
        {bus.in1, bus.in0} = 2'b01;
        @(negedge clkpos);
        check("pre_rst_b_valid", 32'(bus.b_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_b", 32'({bus.b_valid, bus.b}), 32'd0);
        check("async_rst_drop", 32'(bus.drop_cnt), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) q_exp[i].delete();
        exp_drop = 8'd0;
        @(negedge clkpos);
        rstn = 1'b1;
        repeat (2) @(negedge clkpos);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("q_%s_drained", ch_name[i]), 32'(q_exp[i].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
